// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if
//   Request/acknowledge/return handshake between the interrupt controller
//   and the Control unit.
//   irq_ack      Control -> controller, one-cycle pulse: interrupt taken
//   irq_return   Control -> controller, one-cycle pulse: OS returned to user
//   interruption controller -> Control, 2-bit code (00 none, 01 quantum,
//                10 user request, 11 IO)
//   irq_pending  controller -> Control, pending vector {io, user, quantum}
interface interrupt_controller_if;
    logic       irq_ack;
    logic       irq_return;
    logic [1:0] interruption;
    logic [2:0] irq_pending;

    // Control unit side
    modport master (
        output irq_ack,
        output irq_return,
        input  interruption,
        input  irq_pending
    );

    // Interrupt controller side
    modport slave (
        input  irq_ack,
        input  irq_return,
        output interruption,
        output irq_pending
    );
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller
//   Arbitrates the quantum timer, the user OS-request button and the IO
//   input request, and sequences the request/ack/return handshake with
//   the Control unit.
//   fast_clock     single clock
//   reset          asynchronous active-low reset
//   step           one-cycle pulse per retired instruction
//   is_os          high while OS code runs (freezes quantum timer)
//   user_request   debounced button level (rising edge is the event)
//   io_request     IO input request level
//   quantum_load   load quantum_value into reload register and counter
//   quantum_value  new quantum length, 0 disables the timer
//   quantum_count  current quantum counter value
//   irq_bus        handshake with Control (see interrupt_controller_if)
module interrupt_controller #(
    parameter int unsigned QUANTUM_WIDTH   = 16,
    parameter int unsigned QUANTUM_DEFAULT = 1000
) (
    input  logic                     fast_clock,
    input  logic                     reset,
    input  logic                     step,
    input  logic                     is_os,
    input  logic                     user_request,
    input  logic                     io_request,
    input  logic                     quantum_load,
    input  logic [QUANTUM_WIDTH-1:0] quantum_value,
    output logic [QUANTUM_WIDTH-1:0] quantum_count,
    interrupt_controller_if.slave    irq_bus
);

    localparam logic [QUANTUM_WIDTH-1:0] RELOAD_RST = QUANTUM_WIDTH'(QUANTUM_DEFAULT);
    localparam logic [QUANTUM_WIDTH-1:0] ONE        = QUANTUM_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        SERVICE
    } state_t;

    state_t                   state, state_next;
    logic [1:0]               code_q;
    logic [1:0]               arb_code;
    logic [2:0]               pending_q, pending_next;
    logic [2:0]               clear_mask, set_mask;
    logic                     user_prev;
    logic [QUANTUM_WIDTH-1:0] reload_q, reload_next;
    logic [QUANTUM_WIDTH-1:0] count_q, count_next;
    logic                     expire;
    logic                     ack_take, ret_take;

    // Handshake pulses only act in the state that expects them
    assign ack_take = (state == REQUEST) && irq_bus.irq_ack;
    assign ret_take = (state == SERVICE) && irq_bus.irq_return;

    // Fixed priority: io > user > quantum
    always_comb begin
        arb_code = 2'b00;
        if (pending_q[2])      arb_code = 2'b11;
        else if (pending_q[1]) arb_code = 2'b10;
        else if (pending_q[0]) arb_code = 2'b01;
    end

    // Quantum timer. Load beats return-reload beats decrement; a zero
    // reload value parks the counter and never expires.
    always_comb begin
        reload_next = reload_q;
        count_next  = count_q;
        expire      = 1'b0;
        if (quantum_load) begin
            reload_next = quantum_value;
            count_next  = quantum_value;
        end else if (ret_take) begin
            count_next = reload_q;
        end else if (step && (state == IDLE) && !is_os && (reload_q != '0)) begin
            if (count_q <= ONE) begin
                expire     = 1'b1;
                count_next = reload_q;
            end else begin
                count_next = count_q - ONE;
            end
        end
    end

    // Pending bits: sticky, cleared only by the ack of the served code;
    // a same-edge set overrides the clear.
    always_comb begin
        clear_mask = '0;
        if (ack_take) begin
            case (code_q)
                2'b01:   clear_mask = 3'b001;
                2'b10:   clear_mask = 3'b010;
                2'b11:   clear_mask = 3'b100;
                default: clear_mask = 3'b000;
            endcase
        end
        set_mask     = {io_request, user_request & ~user_prev, expire};
        pending_next = (pending_q & ~clear_mask) | set_mask;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pending_q != '0) state_next = REQUEST;
            REQUEST: if (ack_take)        state_next = SERVICE;
            SERVICE: if (ret_take)        state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge fast_clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers
    always_ff @(posedge fast_clock or negedge reset) begin
        if (!reset) begin
            code_q    <= '0;
            pending_q <= '0;
            user_prev <= 1'b1;  // a button already held at reset is not an event
            reload_q  <= RELOAD_RST;
            count_q   <= RELOAD_RST;
        end else begin
            // Code is captured only when leaving IDLE so it stays stable
            // for the whole REQUEST phase.
            if ((state == IDLE) && (pending_q != '0)) begin
                code_q <= arb_code;
            end
            pending_q <= pending_next;
            user_prev <= user_request;
            reload_q  <= reload_next;
            count_q   <= count_next;
        end
    end

    // Output logic
    always_comb begin
        irq_bus.interruption = (state == REQUEST) ? code_q : 2'b00;
        irq_bus.irq_pending  = pending_q;
        quantum_count        = count_q;
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// tb_interrupt_controller
//   Directed stimulus with a behavioural model compared on every falling
//   edge, plus literal expectations at key points of each scenario.
module tb_interrupt_controller;

    logic        fast_clock;
    logic        reset;
    logic        step;
    logic        is_os;
    logic        user_request;
    logic        io_request;
    logic        quantum_load;
    logic [15:0] quantum_value;
    logic [15:0] quantum_count;

    interrupt_controller_if irq_bus();

    interrupt_controller #(
        .QUANTUM_WIDTH  (16),
        .QUANTUM_DEFAULT(1000)
    ) dut (
        .fast_clock   (fast_clock),
        .reset        (reset),
        .step         (step),
        .is_os        (is_os),
        .user_request (user_request),
        .io_request   (io_request),
        .quantum_load (quantum_load),
        .quantum_value(quantum_value),
        .quantum_count(quantum_count),
        .irq_bus      (irq_bus.slave)
    );

    int errors = 0;
    int checks = 0;

    initial fast_clock = 1'b0;
    always #5 fast_clock = ~fast_clock;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [2:0]  m_pend, p_old;
    logic [1:0]  m_code;
    logic        m_req, m_svc, m_uprev;
    logic [15:0] m_cnt, m_rel;
    logic        idle, ack_ok, ret_ok, expire;

    always @(posedge fast_clock or negedge reset) begin
        if (!reset) begin
            m_pend = '0; m_code = '0; m_req = 0; m_svc = 0; m_uprev = 1;
            m_cnt = 16'd1000; m_rel = 16'd1000;
        end else begin
            idle   = !m_req && !m_svc;
            ack_ok = m_req && irq_bus.irq_ack;
            ret_ok = m_svc && irq_bus.irq_return;
            p_old  = m_pend;
            expire = 0;
            if (quantum_load) begin
                m_rel = quantum_value;
                m_cnt = quantum_value;
            end else if (ret_ok) begin
                m_cnt = m_rel;
            end else if (step && idle && !is_os && m_rel != 0) begin
                if (m_cnt <= 1) begin
                    expire = 1;
                    m_cnt  = m_rel;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
            // code n serves pending bit n-1
            if (ack_ok) m_pend[m_code - 1] = 1'b0;
            if (io_request) m_pend[2] = 1'b1;
            if (user_request && !m_uprev) m_pend[1] = 1'b1;
            if (expire) m_pend[0] = 1'b1;
            if (idle && p_old != 0) begin
                m_req = 1;
                for (int b = 0; b < 3; b++) if (p_old[b]) m_code = 2'(b + 1);
            end else if (ack_ok) begin
                m_req = 0;
                m_svc = 1;
            end else if (ret_ok) begin
                m_svc = 0;
            end
            m_uprev = user_request;
        end
    end

    always @(negedge fast_clock) begin
        if (reset === 1'b1) begin
            check("mdl_interruption", 32'(irq_bus.interruption), 32'(m_req ? m_code : 2'b00));
            check("mdl_pending", 32'(irq_bus.irq_pending), 32'(m_pend));
            check("mdl_count", 32'(quantum_count), 32'(m_cnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge fast_clock);
        #1;
    endtask

    task automatic pulse_ack;
        irq_bus.irq_ack = 1'b1; tick; irq_bus.irq_ack = 1'b0;
    endtask

    task automatic pulse_ret;
        irq_bus.irq_return = 1'b1; tick; irq_bus.irq_return = 1'b0;
    endtask

    task automatic pulse_step;
        step = 1'b1; tick; step = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b0; step = 0; is_os = 0; user_request = 1; io_request = 0;
        quantum_load = 0; quantum_value = '0;
        irq_bus.irq_ack = 0; irq_bus.irq_return = 0;
        #23;
        reset = 1'b1;

        // Held button across reset release is not an event
        for (int i = 0; i < 20; i++) begin
            tick;
            check("held_btn_int", 32'(irq_bus.interruption), 32'd0);
            check("held_btn_pend", 32'(irq_bus.irq_pending), 32'd0);
        end
        check("reset_count", 32'(quantum_count), 32'd1000);

        // Quantum of 3
        quantum_value = 16'd3; quantum_load = 1; tick; quantum_load = 0;
        check("load_count", 32'(quantum_count), 32'd3);
        pulse_step; pulse_step; pulse_step;
        check("q_pend", 32'(irq_bus.irq_pending), 32'b001);
        check("q_int_early", 32'(irq_bus.interruption), 32'd0);
        tick;
        check("q_int", 32'(irq_bus.interruption), 32'b01);
        pulse_ack;
        check("q_ack_int", 32'(irq_bus.interruption), 32'd0);
        check("q_ack_pend", 32'(irq_bus.irq_pending), 32'd0);
        pulse_ret;
        check("q_ret_count", 32'(quantum_count), 32'd3);

        // Simultaneous user edge and IO: IO first, then user
        user_request = 0; tick;
        user_request = 1; io_request = 1; tick;
        check("ui_pend", 32'(irq_bus.irq_pending), 32'b110);
        check("ui_int_early", 32'(irq_bus.interruption), 32'd0);
        tick;
        check("ui_int_io", 32'(irq_bus.interruption), 32'b11);
        io_request = 0;
        pulse_ack;
        check("ui_ack_pend", 32'(irq_bus.irq_pending), 32'b010);
        pulse_ret;
        check("ui_idle_gap", 32'(irq_bus.interruption), 32'd0);
        tick;
        check("ui_int_user", 32'(irq_bus.interruption), 32'b10);
        pulse_ack; pulse_ret;

        // Higher-priority event during REQUEST does not preempt
        pulse_step; pulse_step; pulse_step; tick;
        check("pre_int_q", 32'(irq_bus.interruption), 32'b01);
        io_request = 1; tick; io_request = 0;
        check("pre_int_hold", 32'(irq_bus.interruption), 32'b01);
        check("pre_pend", 32'(irq_bus.irq_pending), 32'b101);
        pulse_ack;
        check("pre_ack_pend", 32'(irq_bus.irq_pending), 32'b100);
        pulse_ret;
        check("pre_gap", 32'(irq_bus.interruption), 32'd0);
        tick;
        check("pre_int_io", 32'(irq_bus.interruption), 32'b11);
        pulse_ack; pulse_ret;

        // OS freezes the timer; zero quantum disables it
        is_os = 1; step = 1;
        repeat (50) tick;
        step = 0; is_os = 0;
        check("os_freeze", 32'(quantum_count), 32'd3);
        quantum_value = 16'd0; quantum_load = 1; tick; quantum_load = 0;
        step = 1;
        repeat (10000) tick;
        step = 0;
        check("zero_q_pend", 32'(irq_bus.irq_pending), 32'd0);
        check("zero_q_int", 32'(irq_bus.interruption), 32'd0);
        check("zero_q_count", 32'(quantum_count), 32'd0);

        // Reset in SERVICE; IO held through the ack re-sets its own bit
        user_request = 0; tick;
        user_request = 1; io_request = 1; tick; tick;
        check("svc_int", 32'(irq_bus.interruption), 32'b11);
        pulse_ack;
        check("svc_pend", 32'(irq_bus.irq_pending), 32'b110);
        io_request = 0;
        #2;
        reset = 1'b0;
        #1;
        check("async_int", 32'(irq_bus.interruption), 32'd0);
        check("async_pend", 32'(irq_bus.irq_pending), 32'd0);
        check("async_count", 32'(quantum_count), 32'd1000);
        #3;
        reset = 1'b1;
        tick;
        pulse_ack;
        check("stray_ack_int", 32'(irq_bus.interruption), 32'd0);
        check("stray_ack_pend", 32'(irq_bus.irq_pending), 32'd0);
        pulse_ret;
        check("stray_ret_count", 32'(quantum_count), 32'd1000);
        tick;
        check("stray_int", 32'(irq_bus.interruption), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
